// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// The slave side is the arbiter; the master side is the environment.
interface mem_arbiter_if #(
  parameter int AW = 10
);
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_done;
  logic [31:0]   i_rdata;
  logic          i_stall;

  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_done;
  logic [31:0]   d_rdata;
  logic          d_stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output i_done, i_rdata, i_stall,
    output d_done, d_rdata, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  i_done, i_rdata, i_stall,
    input  d_done, d_rdata, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory, one access in flight.
// Data has priority; a saturating counter guards fetch from starvation.
module mem_arbiter #(
  parameter int LAT        = 2,
  parameter int AW         = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    lat_cnt;
  logic [SW-1:0] starve;

  logic          win_i;
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  logic [31:0]   cap_wdata;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;

  logic          req_any;
  logic          grant_i;
  logic          last_wait;
  logic          unused;

  assign req_any   = bus.i_req | bus.d_req;
  assign grant_i   = bus.i_req &
                     (~bus.d_req | (starve == SW'(STARVE_MAX)));
  assign last_wait = (lat_cnt == 4'(LAT - 1));

  // Byte-lane and high address bits are don't-care.
  assign unused = ^{bus.i_addr[1:0], bus.i_addr[31:AW+2],
                    bus.d_addr[1:0], bus.d_addr[31:AW+2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_any) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (last_wait) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (state == WAIT) begin
      lat_cnt <= lat_cnt + 4'd1;
    end else begin
      lat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_i     <= 1'b0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
    end else if (state == IDLE && req_any) begin
      win_i     <= grant_i;
      cap_addr  <= grant_i ? bus.i_addr[AW+1:2]
                           : bus.d_addr[AW+1:2];
      cap_we    <= ~grant_i & bus.d_we;
      cap_wdata <= grant_i ? 32'h0 : bus.d_wdata;
    end
  end

  // A cycle with fetch waiting and not granted counts as a lost round.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (!bus.i_req || grant_i) begin
        starve <= '0;
      end else if (starve != SW'(STARVE_MAX)) begin
        starve <= starve + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (state == WAIT && last_wait) begin
      if (win_i) begin
        i_rdata_q <= bus.mem_rdata;
      end else if (!cap_we) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = cap_we;
      bus.mem_addr  = cap_addr;
      bus.mem_wdata = cap_wdata;
    end
  end

  assign bus.i_done  = (state == DONE) & win_i;
  assign bus.d_done  = (state == DONE) & ~win_i;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_stall = bus.i_req & ~bus.i_done;
  assign bus.d_stall = bus.d_req & ~bus.d_done;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a
// transaction-level model of grant order, memory and read data.
module tb_mem_arbiter;

  localparam int LAT   = 2;
  localparam int AW    = 10;
  localparam int SMAX  = 3;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic load_go;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW)) bus();

  mem_arbiter #(
    .LAT(LAT),
    .AW(AW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] init_fn(input int i);
    if (i == 4) return 32'h8C08_0004;
    return (i * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Memory device: registered read pipeline, data valid LAT cycles
  // after the strobe.
  logic [31:0] ram [DEPTH];
  logic [31:0] pipe [LAT];

  always @(posedge clk) begin
    if (load_go) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_fn(i);
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    pipe[0] <= bus.mem_en ? ram[bus.mem_addr] : 32'h0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.mem_rdata = pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mdl [DEPTH];
  int          m_starve;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;
  int          n_dwin;
  int          n_iwin;

  logic        s_ir, s_dr, s_dwe;
  logic [31:0] s_ia, s_da, s_dwd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_req   = s_ir;
    bus.i_addr  = s_ia;
    bus.d_req   = s_dr;
    bus.d_we    = s_dwe;
    bus.d_addr  = s_da;
    bus.d_wdata = s_dwd;
  endtask

  // Called #1 after an edge with the arbiter in IDLE and inputs set.
  task automatic txn();
    logic          gi, st, di, dd;
    logic [AW-1:0] wa;
    logic [31:0]   rv;
    if (!s_ir && !s_dr) begin
      m_starve = 0;
      @(posedge clk); #1;
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
      return;
    end
    gi = s_ir && (!s_dr || m_starve == SMAX);
    if (gi || !s_ir) m_starve = 0;
    else if (m_starve < SMAX) m_starve++;
    if (gi) n_iwin++;
    else n_dwin++;
    wa = gi ? s_ia[AW+1:2] : s_da[AW+1:2];
    st = !gi && s_dwe;
    rv = mdl[wa];
    if (st) mdl[wa] = s_dwd;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      di = (k == LAT + 2) && gi;
      dd = (k == LAT + 2) && !gi;
      if (k == LAT + 2) begin
        if (gi) m_irdata = rv;
        else if (!st) m_drdata = rv;
      end
      chk("mem_en", 32'(bus.mem_en), 32'(k == 1));
      chk("mem_addr", 32'(bus.mem_addr),
          (k == 1) ? 32'(wa) : 32'd0);
      chk("mem_we", 32'(bus.mem_we), 32'(k == 1 && st));
      if (!(k == 1 && gi))
        chk("mem_wdata", bus.mem_wdata,
            (k == 1) ? s_dwd : 32'd0);
      chk("i_done", 32'(bus.i_done), 32'(di));
      chk("d_done", 32'(bus.d_done), 32'(dd));
      chk("busy", 32'(bus.busy), 32'(k <= LAT + 2));
      chk("i_stall", 32'(bus.i_stall), 32'(s_ir && !di));
      chk("d_stall", 32'(bus.d_stall), 32'(s_dr && !dd));
      chk("i_rdata", bus.i_rdata, m_irdata);
      chk("d_rdata", bus.d_rdata, m_drdata);
    end
    if (gi) s_ir = 1'b0;
    else s_dr = 1'b0;
    drive();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = init_fn(i);
    m_starve = 0;
    m_irdata = '0;
    m_drdata = '0;
    n_dwin   = 0;
    n_iwin   = 0;
    s_ir = 0; s_dr = 0; s_dwe = 0;
    s_ia = 0; s_da = 0; s_dwd = 0;
    drive();
    load_go = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    load_go = 1'b0;

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_i_done", 32'(bus.i_done), 32'd0);
    chk("rst_d_done", 32'(bus.d_done), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    reset = 1'b0;

    // Lone fetch of word 4
    s_ir = 1; s_ia = 32'h10;
    drive();
    txn();
    chk("fetch_word4", bus.i_rdata, 32'h8C08_0004);

    // Store then load at 0x20
    s_dr = 1; s_dwe = 1; s_da = 32'h20; s_dwd = 32'hDEAD_BEEF;
    drive();
    txn();
    s_dr = 1; s_dwe = 0; s_da = 32'h20; s_dwd = $urandom;
    drive();
    txn();
    chk("load_back", bus.d_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests: data first, then fetch
    n_dwin = 0; n_iwin = 0;
    s_ir = 1; s_ia = $urandom;
    s_dr = 1; s_dwe = 0; s_da = $urandom;
    drive();
    txn();
    chk("both_data_first", 32'(n_dwin), 32'd1);
    txn();
    chk("both_fetch_next", 32'(n_iwin), 32'd1);

    // Starvation guard: fetch held, data re-requests each round
    n_dwin = 0; n_iwin = 0;
    s_ir = 1; s_ia = $urandom;
    for (int r = 0; r < SMAX + 1; r++) begin
      s_dr = 1; s_dwe = 1'($urandom); s_da = $urandom;
      s_dwd = $urandom;
      drive();
      txn();
    end
    chk("starve_dwins", 32'(n_dwin), 32'(SMAX));
    chk("starve_iwins", 32'(n_iwin), 32'd1);
    chk("starve_cleared", 32'(m_starve), 32'd0);
    s_ir = 1; s_ia = $urandom;
    drive();
    n_dwin = 0;
    txn();
    chk("after_starve_data", 32'(n_dwin), 32'd1);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      if (!s_ir) begin
        s_ir = 1'($urandom_range(0, 2) != 0);
        s_ia = $urandom;
      end
      if (!s_dr) begin
        s_dr  = 1'($urandom_range(0, 2) != 0);
        s_dwe = 1'($urandom);
        s_da  = {$urandom_range(0, 255), 2'($urandom)};
        s_dwd = $urandom;
      end
      drive();
      txn();
    end
    for (int r = 0; r < 3; r++) if (s_ir || s_dr) txn();

    // Reset during WAIT abandons the load
    s_dr = 1; s_dwe = 0; s_da = 32'h24;
    drive();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    m_starve = 0;
    m_irdata = '0;
    m_drdata = '0;
    chk("wrst_busy", 32'(bus.busy), 32'd0);
    chk("wrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("wrst_i_done", 32'(bus.i_done), 32'd0);
    chk("wrst_d_done", 32'(bus.d_done), 32'd0);
    chk("wrst_i_rdata", bus.i_rdata, 32'd0);
    chk("wrst_d_rdata", bus.d_rdata, 32'd0);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      chk("wrst_hold_done", 32'(bus.d_done), 32'd0);
      chk("wrst_hold_en", 32'(bus.mem_en), 32'd0);
    end
    reset = 1'b0;
    s_dr = 0;
    s_ir = 1; s_ia = {$urandom_range(0, 1023), 2'b00};
    drive();
    txn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
